dice_roller: RTL and testbench

Produces the dice total that feeds the craps outcome decoder.
- Two free-running 1..6 counters generate the dice values.
- A player's roll request starts a roll and enforces a minimum roll duration.
- On completion it latches both dice and their sum, then issues a single-cycle valid strobe that drives the decoder's clock_en/num inputs.
- While rolling, the die outputs animate so the 7-segment display shows tumbling dice.

---
 rtl/dice_roller.sv | 72 +++++++
 tb/tb_dice_roller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// dice_roller: free-running dice pair, latched on a timed roll and strobed to the craps decoder
module dice_roller #(
  parameter int ROLL_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       roll,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] num,
  output logic       num_valid,
  output logic       busy
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ROLLING = 2'd1;
  localparam logic [1:0] REPORT  = 2'd2;
  localparam logic [7:0] LAST    = 8'(ROLL_CYCLES - 1);
  logic [1:0] state;
  logic [2:0] f1, f2;
  logic [7:0] cnt;
  logic       roll_q, armed, rise, done;
  // armed masks the first edge so a roll already held at reset release is not a rise
  assign rise      = roll & ~roll_q & armed;
  // cnt holds the number of ROLLING cycles already completed before this edge
  assign done      = (cnt == LAST) & ~roll;
  assign num_valid = state == REPORT;
  assign busy      = state != IDLE;
  // two chained 1..6 counters; f2 advances when f1 wraps, giving all 36 pairs per period
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      f1 <= 3'd1;
      f2 <= 3'd1;
    end else begin
      f1 <= (f1 == 3'd6) ? 3'd1 : f1 + 3'd1;
      if (f1 == 3'd6) f2 <= (f2 == 3'd6) ? 3'd1 : f2 + 3'd1;
    end
  // roll edge detector history
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      roll_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      roll_q <= roll;
      armed  <= 1'b1;
    end
  // roll sequencer: animate dice while rolling, latch on exit, strobe for one cycle
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      die1  <= 3'd0;
      die2  <= 3'd0;
      num   <= 4'd0;
    end else begin
      case (state)
        IDLE: if (rise) begin
          state <= ROLLING;
          cnt   <= 8'd0;
        end
        ROLLING: begin
          die1 <= f1;
          die2 <= f2;
          cnt  <= (cnt == LAST) ? cnt : cnt + 8'd1;
          if (done) begin
            num   <= {1'b0, f1} + {1'b0, f2};
            state <= REPORT;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dice_roller.sv
// tb_dice_roller: randomized self-checking bench for two dice_roller instances (ROLL_CYCLES 4 and 16)
module tb_dice_roller;
  logic       clock = 1'b0;
  logic       reset_s [2];
  logic       roll_s  [2];
  logic [2:0] die1_s  [2];
  logic [2:0] die2_s  [2];
  logic [3:0] num_s   [2];
  logic       nv_s    [2];
  logic       busy_s  [2];
  int         na      [2];
  logic [2:0] ed1     [2];
  logic [2:0] ed2     [2];
  logic [3:0] en      [2];
  int         checks = 0;
  int         failures = 0;
  bit         cov [36];

  dice_roller #(.ROLL_CYCLES(4)) dut_a (
    .clock(clock), .reset(reset_s[0]), .roll(roll_s[0]),
    .die1(die1_s[0]), .die2(die2_s[0]), .num(num_s[0]),
    .num_valid(nv_s[0]), .busy(busy_s[0])
  );

  dice_roller #(.ROLL_CYCLES(16)) dut_b (
    .clock(clock), .reset(reset_s[1]), .roll(roll_s[1]),
    .die1(die1_s[1]), .die2(die2_s[1]), .num(num_s[1]),
    .num_valid(nv_s[1]), .busy(busy_s[1])
  );

  always #5 clock = ~clock;

  // edges seen since each instance's reset was released
  always @(posedge clock)
    for (int d = 0; d < 2; d++) na[d] <= reset_s[d] ? 0 : na[d] + 1;

  function automatic logic [2:0] fv1(input int n);
    return 3'(n % 6 + 1);
  endfunction

  function automatic logic [2:0] fv2(input int n);
    return 3'((n / 6) % 6 + 1);
  endfunction

  task automatic zero_model(input int d);
    ed1[d] = 3'd0;
    ed2[d] = 3'd0;
    en[d]  = 4'd0;
  endtask

  task automatic apply_reset(input int d);
    @(negedge clock);
    reset_s[d] = 1'b1;
    roll_s[d]  = 1'b0;
    @(negedge clock);
    reset_s[d] = 1'b0;
    zero_model(d);
  endtask

  // Roll held for h edges, optional one-edge pulse at offset p (p<exit), optional pulse during REPORT.
  // The exit edge is the first offset >= ROLL_CYCLES with roll low; starts and ends on a negedge.
  task automatic run_roll(input int d, input int h, input int p, input bit rpt);
    int r, base, x, pulses;
    r = d ? 16 : 4;
    x = (h > r) ? h : r;
    base = na[d];
    pulses = 0;
    for (int o = 0; o <= x + 4; o++) begin
      roll_s[d] = (o < h) || (o == p) || (rpt && o == x + 1);
      @(negedge clock);
      if (o >= 1 && o <= x) begin
        ed1[d] = fv1(base + o);
        ed2[d] = fv2(base + o);
      end
      if (o == x) en[d] = 4'(ed1[d]) + 4'(ed2[d]);
      checks++;
      if (die1_s[d] !== ed1[d]) begin
        failures++;
        $display("FAIL roll_die1 dut=%0d step=%0d got=%0d exp=%0d", d, o, die1_s[d], ed1[d]);
      end
      checks++;
      if (die2_s[d] !== ed2[d]) begin
        failures++;
        $display("FAIL roll_die2 dut=%0d step=%0d got=%0d exp=%0d", d, o, die2_s[d], ed2[d]);
      end
      checks++;
      if (num_s[d] !== en[d]) begin
        failures++;
        $display("FAIL roll_num dut=%0d step=%0d got=%0d exp=%0d", d, o, num_s[d], en[d]);
      end
      checks++;
      if (nv_s[d] !== (o == x)) begin
        failures++;
        $display("FAIL roll_valid dut=%0d step=%0d got=%b exp=%b", d, o, nv_s[d], o == x);
      end
      checks++;
      if (busy_s[d] !== (o <= x)) begin
        failures++;
        $display("FAIL roll_busy dut=%0d step=%0d got=%b exp=%b", d, o, busy_s[d], o <= x);
      end
      if (nv_s[d] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL roll_pulses dut=%0d got=%0d exp=1", d, pulses);
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      reset_s[d] = 1'b1;
      roll_s[d]  = 1'b0;
    end
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      reset_s[d] = 1'b0;
      zero_model(d);
    end
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({die1_s[d], die2_s[d], num_s[d], nv_s[d], busy_s[d]} !== 12'd0) begin
          failures++;
          $display("FAIL idle_outputs dut=%0d cycle=%0d got=%h exp=0", d, i,
                   {die1_s[d], die2_s[d], num_s[d], nv_s[d], busy_s[d]});
        end
      end
    end
    checks++;
    if (dut_a.f1 !== fv1(50) || dut_a.f2 !== fv2(50)) begin
      failures++;
      $display("FAIL free_counters got=%0d,%0d exp=%0d,%0d", dut_a.f1, dut_a.f2, fv1(50), fv2(50));
    end
    checks++;
    if (dut_b.f1 !== fv1(na[1]) || dut_b.f2 !== fv2(na[1])) begin
      failures++;
      $display("FAIL free_counters_b got=%0d,%0d exp=%0d,%0d", dut_b.f1, dut_b.f2, fv1(na[1]), fv2(na[1]));
    end
  endtask

  task automatic test_release_high;
    @(negedge clock);
    reset_s[0] = 1'b1;
    roll_s[0]  = 1'b1;
    @(negedge clock);
    reset_s[0] = 1'b0;
    zero_model(0);
    repeat (6) begin
      @(negedge clock);
      checks++;
      if (busy_s[0] !== 1'b0) begin
        failures++;
        $display("FAIL release_high_busy got=%b exp=0", busy_s[0]);
      end
    end
    roll_s[0] = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_short;
    apply_reset(0);
    repeat ($urandom_range(0, 9)) @(negedge clock);
    run_roll(0, 1, -1, 1'b0);
    checks++;
    if (num_s[0] !== 4'(die1_s[0]) + 4'(die2_s[0])) begin
      failures++;
      $display("FAIL short_sum got=%0d exp=%0d", num_s[0], 4'(die1_s[0]) + 4'(die2_s[0]));
    end
  endtask

  task automatic test_known;
    apply_reset(0);
    for (int w = 0; w < 50 && na[0] < 37; w++) @(negedge clock);
    run_roll(0, 1, -1, 1'b0);
    checks++;
    if (die1_s[0] !== 3'd6 || die2_s[0] !== 3'd1 || num_s[0] !== 4'd7 || busy_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL known_value got=%0d,%0d,%0d busy=%b exp=6,1,7 busy=0",
               die1_s[0], die2_s[0], num_s[0], busy_s[0]);
    end
  endtask

  task automatic test_long_hold;
    run_roll(1, 100, -1, 1'b0);
  endtask

  task automatic test_retrigger;
    run_roll(0, 1, 2, 1'b1);
    run_roll(0, 1, -1, 1'b0);
    run_roll(1, 3, 9, 1'b1);
    run_roll(1, 2, -1, 1'b0);
  endtask

  task automatic test_reset_mid;
    run_roll(0, 1, -1, 1'b0);
    @(negedge clock);
    roll_s[0] = 1'b1;
    @(negedge clock);
    roll_s[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (busy_s[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy_before got=%b exp=1", busy_s[0]);
    end
    @(posedge clock);
    #3 reset_s[0] = 1'b1;
    #1;
    zero_model(0);
    checks++;
    if ({die1_s[0], die2_s[0], num_s[0], nv_s[0], busy_s[0]} !== 12'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h exp=0", {die1_s[0], die2_s[0], num_s[0], nv_s[0], busy_s[0]});
    end
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (nv_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_hold got=%b%b exp=00", nv_s[0], busy_s[0]);
      end
    end
    reset_s[0] = 1'b0;
    repeat (4) begin
      @(negedge clock);
      checks++;
      if (nv_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_after got=%b%b exp=00", nv_s[0], busy_s[0]);
      end
    end
  endtask

  task automatic test_sweep;
    int seen;
    for (int k = 0; k < 36; k++) cov[k] = 1'b0;
    for (int k = 0; k < 36; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      for (int w = 0; w < 40 && (na[0] + 4) % 36 != k; w++) @(negedge clock);
      checks++;
      if ((na[0] + 4) % 36 != k) begin
        failures++;
        $display("FAIL sweep_align got=%0d exp=%0d", (na[0] + 4) % 36, k);
      end
      run_roll(0, $urandom_range(1, 4), -1, 1'b0);
      checks++;
      if (num_s[0] < 4'd2 || num_s[0] > 4'd12) begin
        failures++;
        $display("FAIL sweep_range got=%0d exp=2..12", num_s[0]);
      end
      if (die1_s[0] >= 3'd1 && die1_s[0] <= 3'd6 && die2_s[0] >= 3'd1 && die2_s[0] <= 3'd6)
        cov[(int'(die1_s[0]) - 1) * 6 + int'(die2_s[0]) - 1] = 1'b1;
    end
    seen = 0;
    for (int k = 0; k < 36; k++) seen += int'(cov[k]);
    checks++;
    if (seen != 36) begin
      failures++;
      $display("FAIL sweep_pairs got=%0d exp=36", seen);
    end
  endtask

  task automatic test_random;
    int d, r, h, x, p;
    for (int i = 0; i < 12; i++) begin
      d = $urandom_range(0, 1);
      r = d ? 16 : 4;
      h = $urandom_range(1, r + 3);
      x = (h > r) ? h : r;
      p = (h + 1 < x && $urandom_range(0, 1) == 1) ? $urandom_range(h + 1, x - 1) : -1;
      repeat ($urandom_range(0, 5)) @(negedge clock);
      run_roll(d, h, p, 1'(($urandom_range(0, 1))));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset_s[d] = 1'b1;
      roll_s[d]  = 1'b0;
      zero_model(d);
    end
    test_reset;
    test_release_high;
    test_short;
    test_known;
    test_long_hold;
    test_retrigger;
    test_reset_mid;
    test_sweep;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
